// File: rtl/decoder_pipe.sv
// Pipelined N-to-2^N one-hot/thermometer decoder behind a 2-entry skid buffer.
// Optional accumulator (clr/ACC ports) enabled by defining DECODER_PIPE_ACCUM_EN.
module decoder_pipe #(
    parameter int N = 4
) (
    input  logic                CLK,
    input  logic                ASYNCRESETN,
    input  logic                I_valid,
    output logic                I_ready,
    input  logic [N-1:0]        I,
    input  logic                mode,
    output logic                O_valid,
    input  logic                O_ready,
    output logic [(1<<N)-1:0]   O
`ifdef DECODER_PIPE_ACCUM_EN
    ,
    input  logic                clr,
    output logic [(1<<N)-1:0]   ACC
`endif
);

    localparam int W = 1 << N;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   or_data_q, or_data_d;
    logic [W-1:0]   sk_data_q, sk_data_d;
    logic           o_valid_q, o_valid_d;
    logic           i_ready_q, i_ready_d;
    logic [W-1:0]   dec;
    logic           in_xfer;
    logic           out_xfer;

    assign in_xfer  = I_valid && i_ready_q;
    assign out_xfer = o_valid_q && O_ready;

    always_comb begin
        dec = '0;
        for (int k = 0; k < W; k++) begin
            dec[k] = mode ? (k <= int'(I)) : (k == int'(I));
        end
    end

    always_comb begin
        state_d   = state_q;
        or_data_d = or_data_q;
        sk_data_d = sk_data_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d   = ST_ONE;
                    or_data_d = dec;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    or_data_d = dec;
                end else if (in_xfer) begin
                    state_d   = ST_FULL;
                    sk_data_d = dec;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // input is blocked here, so only the drain path exists
                if (out_xfer) begin
                    state_d   = ST_ONE;
                    or_data_d = sk_data_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        o_valid_d = (state_d != ST_EMPTY);
        i_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q   <= ST_EMPTY;
            or_data_q <= '0;
            sk_data_q <= '0;
            o_valid_q <= 1'b0;
            i_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            or_data_q <= or_data_d;
            sk_data_q <= sk_data_d;
            o_valid_q <= o_valid_d;
            i_ready_q <= i_ready_d;
        end
    end

    assign O       = or_data_q;
    assign O_valid = o_valid_q;
    assign I_ready = i_ready_q;

`ifdef DECODER_PIPE_ACCUM_EN
    logic [W-1:0] acc_q, acc_d;

    // clear applies first so a same-cycle transfer survives the clear
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end
        if (out_xfer) begin
            acc_d = acc_d | or_data_q;
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign ACC = acc_q;
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// Scoreboard bench for decoder_pipe (N=4): stimulus pushes expected words,
// a negedge monitor pops and compares on every output transfer.
module tb_decoder_pipe;

    logic        CLK;
    logic        ASYNCRESETN;
    logic        I_valid;
    logic        I_ready;
    logic [3:0]  I;
    logic        mode;
    logic        O_valid;
    logic        O_ready;
    logic [15:0] O;
`ifdef DECODER_PIPE_ACCUM_EN
    logic        clr;
    logic [15:0] ACC;
`endif

    decoder_pipe #(.N(4)) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .I_valid     (I_valid),
        .I_ready     (I_ready),
        .I           (I),
        .mode        (mode),
        .O_valid     (O_valid),
        .O_ready     (O_ready),
        .O           (O)
`ifdef DECODER_PIPE_ACCUM_EN
        ,
        .clr         (clr),
        .ACC         (ACC)
`endif
    );

    typedef struct {
        logic [15:0] data;
        int          acc_cyc;
        bit          lat;
    } sb_entry_t;

    sb_entry_t exp_q[$];
    int        n_pass  = 0;
    int        n_total = 0;
    int        cyc     = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Presents one word, waits (bounded) for I_ready, queues the hand-computed result.
    task automatic send(input logic [3:0] idx, input logic m, input logic [15:0] exp, input bit lat);
        int guard;
        sb_entry_t e;
        guard   = 0;
        I_valid = 1'b1;
        I       = idx;
        mode    = m;
        while (!I_ready && guard < 50) begin
            @(posedge CLK); #1;
            guard++;
        end
        if (guard >= 50) begin
            chk("send_timeout", 32'(guard), 32'd0);
            I_valid = 1'b0;
        end else begin
            e.data    = exp;
            e.acc_cyc = cyc + 1;
            e.lat     = lat;
            exp_q.push_back(e);
            @(posedge CLK); #1;
            I_valid = 1'b0;
        end
    endtask

    always @(negedge CLK) begin
        if (ASYNCRESETN && O_valid && O_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 32'(O), 32'hDEAD_BEEF);
            end else begin
                sb_entry_t e;
                e = exp_q.pop_front();
                chk("o_data", 32'(O), 32'(e.data));
                if (e.lat) chk("latency", 32'(cyc), 32'(e.acc_cyc));
            end
        end
    end

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(posedge CLK); #1;
            guard++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        ASYNCRESETN = 1'b1;
        I_valid     = 1'b0;
        I           = '0;
        mode        = 1'b0;
        O_ready     = 1'b1;
`ifdef DECODER_PIPE_ACCUM_EN
        clr         = 1'b0;
`endif
        #2 ASYNCRESETN = 1'b0;
        #1;
        chk("rst_o_valid", 32'(O_valid), 32'd0);
        chk("rst_o", 32'(O), 32'h0000);
        chk("rst_i_ready", 32'(I_ready), 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_hold_i_ready", 32'(I_ready), 32'd0);
        ASYNCRESETN = 1'b1;
        #2;
        chk("pre_edge_i_ready", 32'(I_ready), 32'd0);
        @(posedge CLK); #1;
        chk("post_rst_i_ready", 32'(I_ready), 32'd1);
        chk("post_rst_o_valid", 32'(O_valid), 32'd0);

        // one-hot streaming, back-to-back
        send(4'd0,  1'b0, 16'h0001, 1'b1);
        send(4'd5,  1'b0, 16'h0020, 1'b1);
        send(4'd15, 1'b0, 16'h8000, 1'b1);
        wait_drain();

        // thermometer
        send(4'd3,  1'b1, 16'h000F, 1'b1);
        send(4'd15, 1'b1, 16'hFFFF, 1'b1);
        send(4'd0,  1'b1, 16'h0001, 1'b1);
        wait_drain();

        // idle input with garbage must not create words
        I = 4'd9; mode = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("idle_o_valid", 32'(O_valid), 32'd0);

        // backpressure
        O_ready = 1'b0;
        send(4'd1, 1'b0, 16'h0002, 1'b0);
        chk("bp_one_i_ready", 32'(I_ready), 32'd1);
        send(4'd2, 1'b0, 16'h0004, 1'b0);
        chk("bp_full_i_ready", 32'(I_ready), 32'd0);
        chk("bp_o_hold", 32'(O), 32'h0002);
        repeat (2) @(posedge CLK);
        #1;
        chk("bp_o_stable", 32'(O), 32'h0002);
        chk("bp_o_valid_stable", 32'(O_valid), 32'd1);
        chk("bp_still_full", 32'(I_ready), 32'd0);
        O_ready = 1'b1;
        @(posedge CLK); #1;
        chk("bp_drain_o", 32'(O), 32'h0004);
        chk("bp_drain_i_ready", 32'(I_ready), 32'd1);
        wait_drain();

        // async reset while FULL
        O_ready = 1'b0;
        send(4'd10, 1'b0, 16'h0400, 1'b0);
        send(4'd11, 1'b0, 16'h0800, 1'b0);
        chk("mid_full", 32'(I_ready), 32'd0);
        #2 ASYNCRESETN = 1'b0;
        #1;
        chk("mid_rst_o_valid", 32'(O_valid), 32'd0);
        chk("mid_rst_o", 32'(O), 32'h0000);
        chk("mid_rst_i_ready", 32'(I_ready), 32'd0);
        exp_q.delete();
        O_ready = 1'b1;
        @(posedge CLK); #3;
        ASYNCRESETN = 1'b1;
        @(posedge CLK); #1;
        chk("mid_post_i_ready", 32'(I_ready), 32'd1);
        chk("mid_post_o_valid", 32'(O_valid), 32'd0);
        send(4'd6, 1'b0, 16'h0040, 1'b1);
        wait_drain();
        repeat (2) @(posedge CLK);
        #1;
        chk("no_stale", 32'(O_valid), 32'd0);

`ifdef DECODER_PIPE_ACCUM_EN
        ASYNCRESETN = 1'b0;
        #2;
        chk("acc_rst", 32'(ACC), 32'h0000);
        ASYNCRESETN = 1'b1;
        @(posedge CLK); #1;
        send(4'd1, 1'b0, 16'h0002, 1'b1);
        send(4'd4, 1'b0, 16'h0010, 1'b1);
        wait_drain();
        repeat (2) @(posedge CLK);
        #1;
        chk("acc_or", 32'(ACC), 32'h0012);
        send(4'd7, 1'b0, 16'h0080, 1'b1);
        clr = 1'b1;
        @(posedge CLK); #1;
        clr = 1'b0;
        chk("acc_clr_xfer", 32'(ACC), 32'h0080);
        clr = 1'b1;
        @(posedge CLK); #1;
        clr = 1'b0;
        chk("acc_clr", 32'(ACC), 32'h0000);
`endif

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
